// File: rtl/ul_uart_rx_batcher.sv
// UART RX batcher: pops bytes from the RX readback FIFO and packs them
// low-byte-first into 32-bit AXI-stream words. A word goes out when it holds
// 4 bytes, after an idle timeout, or on a software flush.
// Optional statistics counters: define UL_UART_RX_BATCH_STATS_EN.
module ul_uart_rx_batcher #(
  parameter int unsigned BITS_DATA      = 8,
  parameter int unsigned TIMEOUT_CYCLES = 130208,
  parameter int unsigned EMPTY_BIT      = 15
) (
  input  logic        axis_clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        flush_req,
  input  logic [15:0] rx_rdata,
  input  logic        rx_rvalid,
  output logic        rx_rready,
  input  logic        rx_int_valid,
  output logic        rx_int_ready,
  output logic [31:0] out_tdata,
  output logic [3:0]  out_tkeep,
  output logic        out_tlast,
  output logic        out_tvalid,
  input  logic        out_tready,
  output logic        int_valid,
  input  logic        int_ready,
  output logic [15:0] stat_bytes,
  output logic [15:0] stat_timeouts
);

  localparam int unsigned TimerW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TimerW-1:0] TimerMax = TimerW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StCapture, StSettle, StEmit} state_e;

  state_e            state_q, state_d;
  logic [2:0]        count_q, count_d;
  logic [31:0]       data_q, data_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic              last_q, last_d;
  logic              tocause_q, tocause_d;
  logic              flush_pend_q, flush_pend_d;
  logic              int_valid_q, int_valid_d;

  logic avail, flush_eff, timeout_hit, emit, hs;
  logic [3:0] keep;
  logic unused_rdata;

  assign avail       = rx_rvalid & ~rx_rdata[EMPTY_BIT];
  assign flush_eff   = flush_req | flush_pend_q;
  assign timeout_hit = (timer_q == TimerMax);
  assign emit        = (state_q == StEmit);
  assign hs          = emit & out_tready;
  // Only the byte lane and the empty flag matter here.
  assign unused_rdata = ^rx_rdata;

  // Next-state, word assembly, idle timer and pending-flush latch.
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    data_d       = data_q;
    timer_d      = timer_q;
    last_d       = last_q;
    tocause_d    = tocause_q;
    flush_pend_d = flush_pend_q;
    unique case (state_q)
      StIdle: begin
        if (count_q != 3'd0 && !timeout_hit) timer_d = timer_q + TimerW'(1);
        if (enable && avail && count_q < 3'd4) begin
          state_d      = StCapture;
          // A flush seen while a capture wins is kept for the next idle cycle.
          flush_pend_d = flush_eff & (count_q != 3'd0);
        end else if (count_q != 3'd0 && (flush_eff || timeout_hit)) begin
          state_d      = StEmit;
          last_d       = 1'b1;
          tocause_d    = ~flush_eff;
          flush_pend_d = 1'b0;
        end else begin
          if (count_q == 3'd4) begin
            state_d   = StEmit;
            last_d    = 1'b0;
            tocause_d = 1'b0;
          end
          flush_pend_d = 1'b0;
        end
      end
      StCapture: begin
        data_d[{count_q[1:0], 3'b000} +: 8] = rx_rdata[BITS_DATA-1:0];
        count_d      = count_q + 3'd1;
        timer_d      = '0;
        flush_pend_d = flush_pend_q | flush_req;
        state_d      = StSettle;
      end
      StSettle: begin
        flush_pend_d = flush_pend_q | flush_req;
        if (count_q == 3'd4) begin
          state_d   = StEmit;
          last_d    = 1'b0;
          tocause_d = 1'b0;
        end else if (enable && avail) begin
          state_d = StCapture;
        end else begin
          state_d = StIdle;
        end
      end
      StEmit: begin
        if (out_tready) begin
          count_d = 3'd0;
          data_d  = '0;
          timer_d = '0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Host interrupt: set on a burst-ending handshake, set wins over clear.
  always_comb begin
    int_valid_d = int_valid_q & ~int_ready;
    if (hs && last_q) int_valid_d = 1'b1;
  end

  // Byte enables from the number of filled lanes.
  always_comb begin
    keep = 4'b0000;
    unique case (count_q)
      3'd1:    keep = 4'b0001;
      3'd2:    keep = 4'b0011;
      3'd3:    keep = 4'b0111;
      3'd4:    keep = 4'b1111;
      default: keep = 4'b0000;
    endcase
  end

  // State registers.
  always_ff @(posedge axis_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      count_q      <= 3'd0;
      data_q       <= '0;
      timer_q      <= '0;
      last_q       <= 1'b0;
      tocause_q    <= 1'b0;
      flush_pend_q <= 1'b0;
      int_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      data_q       <= data_d;
      timer_q      <= timer_d;
      last_q       <= last_d;
      tocause_q    <= tocause_d;
      flush_pend_q <= flush_pend_d;
      int_valid_q  <= int_valid_d;
    end
  end

  assign rx_rready    = (state_q == StCapture);
  assign rx_int_ready = rx_int_valid & (state_q == StIdle);
  assign out_tvalid   = emit;
  assign out_tdata    = emit ? data_q : 32'h0;
  assign out_tkeep    = emit ? keep : 4'b0000;
  assign out_tlast    = emit & last_q;
  assign int_valid    = int_valid_q;

`ifdef UL_UART_RX_BATCH_STATS_EN
  logic [15:0] stat_bytes_q, stat_bytes_d, stat_to_q, stat_to_d;

  // Byte counter wraps; timeout counter saturates.
  always_comb begin
    stat_bytes_d = stat_bytes_q;
    stat_to_d    = stat_to_q;
    if (state_q == StCapture) stat_bytes_d = stat_bytes_q + 16'd1;
    if (hs && last_q && tocause_q && stat_to_q != 16'hFFFF) stat_to_d = stat_to_q + 16'd1;
  end

  // Statistics registers.
  always_ff @(posedge axis_clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_bytes_q <= 16'd0;
      stat_to_q    <= 16'd0;
    end else begin
      stat_bytes_q <= stat_bytes_d;
      stat_to_q    <= stat_to_d;
    end
  end

  assign stat_bytes    = stat_bytes_q;
  assign stat_timeouts = stat_to_q;
`else
  assign stat_bytes    = 16'd0;
  assign stat_timeouts = 16'd0;
`endif

endmodule
